app_remul_seq: RTL and testbench

//  Sequential multiply-accumulate that rebuilds the dividend from a divider result: x_out = q_in*y_in + r_in.
//  It is the inverse of the 16x8 approximate array divider, used to close the loop on divider accuracy (x vs x_out).

---
 rtl/app_remul_seq_if.sv | 25 ++
 rtl/app_remul_seq.sv | 121 ++++++++++++
 tb/tb_app_remul_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/app_remul_seq_if.sv
// Handshake and data bundle for app_remul_seq.
// master: the producer/consumer side; slave: the multiply-accumulate block.
interface app_remul_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   q_in;
  logic [WIDTH-1:0]   y_in;
  logic [WIDTH-1:0]   r_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] x_out;
  logic               busy;

  modport master (
    output in_valid, q_in, y_in, r_in, out_ready,
    input  in_ready, out_valid, x_out, busy
  );

  modport slave (
    input  in_valid, q_in, y_in, r_in, out_ready,
    output in_ready, out_valid, x_out, busy
  );
endinterface

// File: rtl/app_remul_seq.sv
// app_remul_seq: rebuilds a dividend x_out = q*y + r with a radix-2 shift-add loop.
// The accumulate adder uses approximate cells in its APPROX_BITS low columns so the
// reconstruction error tracks the approximate divider it closes the loop on.
// Optional feature: define APP_REMUL_EARLY_TERM_EN to stop RUN once no quotient bits remain.
module app_remul_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  app_remul_seq_if.slave bus
);

  localparam int unsigned XW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Column k of the adder is approximate when ApproxMask[k] is set.
  localparam logic [XW:0]   MaskFull   = ({{XW{1'b0}}, 1'b1} << APPROX_BITS) - {{XW{1'b0}}, 1'b1};
  localparam logic [XW-1:0] ApproxMask = MaskFull[XW-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [XW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] yreg_q, yreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [XW-1:0]  addend;
  logic [XW-1:0]  sum;
  logic           q_bit;
  logic           last_step;

  assign addend = {{WIDTH{1'b0}}, yreg_q} << cnt_q;
  assign q_bit  = |(qreg_q & ({{(WIDTH-1){1'b0}}, 1'b1} << cnt_q));

`ifdef APP_REMUL_EARLY_TERM_EN
  // Finish once every remaining quotient bit is zero; skipped steps would add nothing.
  assign last_step = ((qreg_q >> (cnt_q + CW'(1))) == '0);
`else
  assign last_step = (cnt_q == CW'(WIDTH - 1));
`endif

  // Ripple adder: approximate cells in the low columns, exact cells above, MSB carry dropped.
  always_comb begin : p_add
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < int'(XW); i++) begin
      if (ApproxMask[i]) begin
        sum[i] = (acc_q[i] ^ addend[i]) | c;
        c      = (acc_q[i] & addend[i]) | c;
      end else begin
        sum[i] = acc_q[i] ^ addend[i] ^ c;
        c      = (acc_q[i] & addend[i]) | (acc_q[i] & c) | (addend[i] & c);
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    qreg_d        = qreg_q;
    yreg_d        = yreg_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.x_out     = '0;
    bus.busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d   = {{WIDTH{1'b0}}, bus.r_in};
          qreg_d  = bus.q_in;
          yreg_d  = bus.y_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        bus.busy = 1'b1;
        if (q_bit) begin
          acc_d = sum;
        end
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.x_out     = acc_q;
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      qreg_q  <= '0;
      yreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qreg_q  <= qreg_d;
      yreg_q  <= yreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_app_remul_seq.sv
// Bench for app_remul_seq: an exact instance (APPROX_BITS=0) and an approximate one
// (APPROX_BITS=2) driven in lockstep and compared against an arithmetic reference.
module tb_app_remul_seq;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] q_in      = '0;
  logic [W-1:0] y_in      = '0;
  logic [W-1:0] r_in      = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  app_remul_seq_if #(.WIDTH(W)) bus_ex ();
  app_remul_seq_if #(.WIDTH(W)) bus_ap ();

  assign bus_ex.in_valid  = in_valid;
  assign bus_ex.out_ready = out_ready;
  assign bus_ex.q_in      = q_in;
  assign bus_ex.y_in      = y_in;
  assign bus_ex.r_in      = r_in;
  assign bus_ap.in_valid  = in_valid;
  assign bus_ap.out_ready = out_ready;
  assign bus_ap.q_in      = q_in;
  assign bus_ap.y_in      = y_in;
  assign bus_ap.r_in      = r_in;

  app_remul_seq #(.WIDTH(W), .APPROX_BITS(0)) dut_ex (.clk(clk), .rst(rst), .bus(bus_ex));
  app_remul_seq #(.WIDTH(W), .APPROX_BITS(2)) dut_ap (.clk(clk), .rst(rst), .bus(bus_ap));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One column-by-column add following the cell definitions (carry out of MSB dropped).
  function automatic logic [15:0] cell_add(input logic [15:0] a, input logic [15:0] b,
                                           input int nap);
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nap) begin
        s[i] = (a[i] ^ b[i]) | c;
        c    = (a[i] & b[i]) | c;
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] ref_x(input logic [7:0] q, input logic [7:0] y,
                                        input logic [7:0] r, input int nap);
    logic [15:0] acc;
    logic [15:0] ye;
    if (nap == 0) return 16'(q) * 16'(y) + 16'(r);
    acc = 16'(r);
    ye  = 16'(y);
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = cell_add(acc, ye << i, nap);
    end
    return acc;
  endfunction

  function automatic int ref_lat(input logic [7:0] q);
`ifdef APP_REMUL_EARLY_TERM_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) if (q[i]) l = i + 1;
    return l;
`else
    return (q == q) ? 8 : 8;
`endif
  endfunction

  // Full transaction: accept, run with junk on ignored inputs, optional backpressure, pop.
  task automatic run_txn(input logic [7:0] q, input logic [7:0] y, input logic [7:0] r,
                         input int hold, output logic [15:0] x_ex, output logic [15:0] x_ap);
    int lat;
    @(negedge clk);
    chk("idle_in_ready", {bus_ex.in_ready, bus_ap.in_ready}, 2'b11);
    in_valid  = 1'b1;
    q_in      = q;
    y_in      = y;
    r_in      = r;
    out_ready = 1'($urandom);
    @(negedge clk);
    chk("run_in_ready", {bus_ex.in_ready, bus_ap.in_ready}, 2'b00);
    chk("run_busy", {bus_ex.busy, bus_ap.busy}, 2'b11);
    lat = 0;
    while (!bus_ex.out_valid && lat < 40) begin
      in_valid  = 1'($urandom);
      q_in      = 8'($urandom);
      y_in      = 8'($urandom);
      r_in      = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    chk("latency", lat, ref_lat(q));
    chk("out_valid_ap", bus_ap.out_valid, 1'b1);
    x_ex = bus_ex.x_out;
    x_ap = bus_ap.x_out;
    chk("x_exact", x_ex, ref_x(q, y, r, 0));
    chk("x_approx", x_ap, ref_x(q, y, r, 2));
    for (int h = 0; h < hold; h++) begin
      q_in = 8'($urandom);
      @(negedge clk);
      chk("hold_x_ex", bus_ex.x_out, x_ex);
      chk("hold_x_ap", bus_ap.x_out, x_ap);
      chk("hold_valid", {bus_ex.out_valid, bus_ap.out_valid}, 2'b11);
      chk("hold_in_ready", {bus_ex.in_ready, bus_ap.in_ready}, 2'b00);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_valid", {bus_ex.out_valid, bus_ap.out_valid}, 2'b00);
    chk("pop_in_ready", {bus_ex.in_ready, bus_ap.in_ready}, 2'b11);
    chk("pop_busy", {bus_ex.busy, bus_ap.busy}, 2'b00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {bus_ex.in_ready, bus_ap.in_ready}, 2'b11);
    chk({tag, "_out_valid"}, {bus_ex.out_valid, bus_ap.out_valid}, 2'b00);
    chk({tag, "_busy"}, {bus_ex.busy, bus_ap.busy}, 2'b00);
    chk({tag, "_x_out"}, {bus_ex.x_out, bus_ap.x_out}, 32'h0);
  endtask

  initial begin
    logic [15:0] xe;
    logic [15:0] xa;

    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_txn(8'hFF, 8'hFF, 8'hFE, 0, xe, xa);
    chk("t1_exact", xe, 16'hFEFF);
    run_txn(8'h05, 8'h10, 8'h03, 0, xe, xa);
    chk("t2_approx", xa, 16'h0053);
    run_txn(8'h01, 8'h01, 8'h01, 0, xe, xa);
    chk("t3_approx", xa, 16'h0006);
    chk("t3_exact", xe, 16'h0002);
    run_txn(8'h9C, 8'h37, 8'h21, 5, xe, xa);

    // Abort three cycles into RUN.
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = 8'hFF;
    y_in     = 8'hFF;
    r_in     = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    run_txn(8'h02, 8'h03, 8'h00, 0, xe, xa);
    chk("after_abort", xe, 16'h0006);

`ifdef APP_REMUL_EARLY_TERM_EN
    run_txn(8'h00, 8'hAA, 8'h11, 0, xe, xa);
    chk("early_q0", xe, 16'h0011);
    run_txn(8'h04, 8'h03, 8'h00, 0, xe, xa);
    chk("early_q4", xe, 16'h000C);
`endif

    for (int v = 0; v < 1000; v++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), xe, xa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
